// File: rtl/decode_stage_p.sv
// RV32 instruction-decode stage: register file with write-through bypass, control
// decode, immediate generation, ID-resolved BEQ/BNE/JAL, hazard stalls and ID/EX register.
module decode_stage_p #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NREGS        = 32,
    parameter int unsigned WRITE_BYPASS = 1,
    localparam int unsigned AW          = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_id_valid,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic            wb_enable,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic [AW-1:0]   ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [AW-1:0]   mem_rd,
    input  logic            mem_mem_read,
    input  logic            flush,
    output logic            pc_enable,
    output logic            if_id_enable,
    output logic            if_flush,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            id_ex_valid,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            alu_src,
    output logic            is_jal,
    output logic [1:0]      alu_op,
    output logic [AW-1:0]   rs1,
    output logic [AW-1:0]   rs2,
    output logic [AW-1:0]   rd,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] reg_a,
    output logic [XLEN-1:0] reg_b,
    output logic [XLEN-1:0] pc_out,
    output logic [6:0]      funct7,
    output logic [2:0]      funct3,
    output logic            illegal,
    output logic [31:0]     stall_cycles
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic            valid;
        logic            mem_to_reg;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic            is_jal;
        logic            illegal;
        logic [1:0]      alu_op;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] reg_a;
        logic [XLEN-1:0] reg_b;
        logic [XLEN-1:0] pc;
        logic [6:0]      funct7;
        logic [2:0]      funct3;
    } idex_t;

    logic [XLEN-1:0] rf_q [NREGS];
    idex_t           idex_d, idex_q;
    logic [31:0]     stall_q;

    logic [6:0]      opcode;
    logic [AW-1:0]   rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0] rdata_a, rdata_b;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_dec;
    logic            known, use1, use2, is_br, is_jal_dec;
    logic            c_m2r, c_rw, c_mr, c_mw, c_src;
    logic [1:0]      c_aluop;
    logic            active, ex_hit, mem_hit, load_use, br_haz, stall, br_cond, taken;

    assign opcode  = instruction[6:0];
    assign rd_idx  = instruction[7 +: AW];
    assign rs1_idx = instruction[15 +: AW];
    assign rs2_idx = instruction[20 +: AW];

    // Same-cycle WB data wins over the stored value so a write and read can overlap.
    assign rdata_a = (rs1_idx == '0) ? '0 :
                     (WRITE_BYPASS != 0 && wb_enable && wb_addr == rs1_idx) ? wb_data : rf_q[rs1_idx];
    assign rdata_b = (rs2_idx == '0) ? '0 :
                     (WRITE_BYPASS != 0 && wb_enable && wb_addr == rs2_idx) ? wb_data : rf_q[rs2_idx];

    assign imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
    assign imm_s = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        known      = 1'b1;
        use1       = 1'b1;
        use2       = 1'b0;
        is_br      = 1'b0;
        is_jal_dec = 1'b0;
        c_m2r      = 1'b0;
        c_rw       = 1'b0;
        c_mr       = 1'b0;
        c_mw       = 1'b0;
        c_src      = 1'b0;
        c_aluop    = 2'b00;
        imm_dec    = '0;
        case (opcode)
            OP_LOAD:   begin c_m2r = 1'b1; c_rw = 1'b1; c_mr = 1'b1; c_src = 1'b1; imm_dec = imm_i; end
            OP_STORE:  begin c_mw = 1'b1; c_src = 1'b1; use2 = 1'b1; imm_dec = imm_s; end
            OP_R:      begin c_rw = 1'b1; c_aluop = 2'b10; use2 = 1'b1; end
            OP_IALU:   begin c_rw = 1'b1; c_src = 1'b1; c_aluop = 2'b11; imm_dec = imm_i; end
            OP_BRANCH: begin c_aluop = 2'b01; use2 = 1'b1; is_br = 1'b1; imm_dec = imm_b; end
            OP_JAL:    begin c_rw = 1'b1; is_jal_dec = 1'b1; use1 = 1'b0; imm_dec = imm_j; end
            default:   begin known = 1'b0; use1 = 1'b0; end
        endcase
    end

    assign active   = if_id_valid && !flush;
    assign ex_hit   = (use1 && rs1_idx != '0 && rs1_idx == ex_rd) ||
                      (use2 && rs2_idx != '0 && rs2_idx == ex_rd);
    assign mem_hit  = (use1 && rs1_idx != '0 && rs1_idx == mem_rd) ||
                      (use2 && rs2_idx != '0 && rs2_idx == mem_rd);
    assign load_use = ex_mem_read && ex_hit;
    assign br_haz   = is_br && ((ex_reg_write && ex_hit) || (mem_mem_read && mem_hit));
    assign stall    = active && (load_use || br_haz);

    assign br_cond  = (instruction[14:12] == 3'b000) ? (rdata_a == rdata_b) :
                      (instruction[14:12] == 3'b001) ? (rdata_a != rdata_b) : 1'b0;
    assign taken    = active && !stall && ((is_br && br_cond) || is_jal_dec);

    assign pc_enable     = !stall;
    assign if_id_enable  = !stall;
    assign branch_taken  = taken;
    assign if_flush      = taken;
    assign branch_target = pc + imm_dec;

    always_comb begin
        idex_d        = '0;
        idex_d.rs1    = rs1_idx;
        idex_d.rs2    = rs2_idx;
        idex_d.rd     = rd_idx;
        idex_d.imm    = imm_dec;
        idex_d.reg_a  = rdata_a;
        idex_d.reg_b  = rdata_b;
        idex_d.pc     = pc;
        idex_d.funct7 = instruction[31:25];
        idex_d.funct3 = instruction[14:12];
        idex_d.illegal = active && !known;
        if (active && !stall && known) begin
            idex_d.valid      = 1'b1;
            idex_d.mem_to_reg = c_m2r;
            idex_d.reg_write  = c_rw;
            idex_d.mem_read   = c_mr;
            idex_d.mem_write  = c_mw;
            idex_d.alu_src    = c_src;
            idex_d.is_jal     = is_jal_dec;
            idex_d.alu_op     = c_aluop;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idex_q  <= '0;
            stall_q <= '0;
            for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            idex_q <= idex_d;
            if (stall && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (wb_enable && wb_addr != '0) rf_q[wb_addr] <= wb_data;
        end
    end

    assign id_ex_valid  = idex_q.valid;
    assign mem_to_reg   = idex_q.mem_to_reg;
    assign reg_write    = idex_q.reg_write;
    assign mem_read     = idex_q.mem_read;
    assign mem_write    = idex_q.mem_write;
    assign alu_src      = idex_q.alu_src;
    assign is_jal       = idex_q.is_jal;
    assign alu_op       = idex_q.alu_op;
    assign rs1          = idex_q.rs1;
    assign rs2          = idex_q.rs2;
    assign rd           = idex_q.rd;
    assign imm          = idex_q.imm;
    assign reg_a        = idex_q.reg_a;
    assign reg_b        = idex_q.reg_b;
    assign pc_out       = idex_q.pc;
    assign funct7       = idex_q.funct7;
    assign funct3       = idex_q.funct3;
    assign illegal      = idex_q.illegal;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed-vector bench for decode_stage_p with hand-computed expectations.
module tb_decode_stage_p;

    logic        clock = 1'b0;
    logic        reset, if_id_valid, wb_enable, ex_reg_write, ex_mem_read, mem_mem_read, flush;
    logic [31:0] instruction, pc, wb_data;
    logic [4:0]  wb_addr, ex_rd, mem_rd;
    logic        pc_enable, if_id_enable, if_flush, branch_taken;
    logic [31:0] branch_target;
    logic        id_ex_valid, mem_to_reg, reg_write, mem_read, mem_write, alu_src, is_jal, illegal;
    logic [1:0]  alu_op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, reg_a, reg_b, pc_out, stall_cycles;
    logic [6:0]  funct7;
    logic [2:0]  funct3;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    decode_stage_p #(.XLEN(32), .NREGS(32), .WRITE_BYPASS(1)) dut (
        .clock(clock), .reset(reset), .if_id_valid(if_id_valid), .instruction(instruction), .pc(pc),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .flush(flush),
        .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_flush(if_flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .id_ex_valid(id_ex_valid), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .is_jal(is_jal),
        .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .reg_a(reg_a), .reg_b(reg_b),
        .pc_out(pc_out), .funct7(funct7), .funct3(funct3), .illegal(illegal),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        return {7'b0, s2, s1, 3'b000, d, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [4:0] d, input logic [4:0] s1,
                                          input logic [11:0] im, input logic [6:0] op);
        return {im, s1, 3'b010, d, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im);
        return {im[11:5], s2, s1, 3'b010, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [2:0] f3, input logic [12:0] im);
        return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] d, input logic [20:0] im);
        return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
    endfunction

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        if_id_valid = 1'b0; wb_enable = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; if_id_valid = 1'b0; instruction = '0; pc = '0;
        wb_enable = 1'b0; wb_addr = '0; wb_data = '0;
        ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_rd = '0; mem_mem_read = 1'b0; flush = 1'b0;
        step(); step();
        check("rst_valid", id_ex_valid, 0);
        check("rst_regwrite", reg_write, 0);
        check("rst_stall", stall_cycles, 0);
        check("rst_pc_en", pc_enable, 1);
        reset = 1'b0;

        // register write then ADD x6,x5,x0
        wb_write(5, 32'h1234);
        if_id_valid = 1'b1; instruction = enc_r(6, 5, 0); pc = 32'h40;
        step();
        check("add_reg_a", reg_a, 32'h1234);
        check("add_reg_b", reg_b, 0);
        check("add_regwrite", reg_write, 1);
        check("add_aluop", alu_op, 2'b10);
        check("add_valid", id_ex_valid, 1);
        check("add_rd", rd, 6);
        check("add_pc", pc_out, 32'h40);
        check("add_alusrc", alu_src, 0);

        // x0 write is ignored
        wb_write(0, 32'hFFFF);
        if_id_valid = 1'b1; instruction = enc_r(6, 0, 0);
        step();
        check("x0_read", reg_a, 0);

        // write-through bypass
        if_id_valid = 1'b1; instruction = enc_r(8, 7, 0);
        wb_enable = 1'b1; wb_addr = 7; wb_data = 32'hAA;
        step();
        wb_enable = 1'b0;
        check("bypass_a", reg_a, 32'hAA);

        wb_write(1, 3);
        wb_write(2, 3);

        // load-use stall
        ex_mem_read = 1'b1; ex_rd = 5;
        if_id_valid = 1'b1; instruction = enc_r(6, 5, 1);
        #1;
        check("lu_pc_en", pc_enable, 0);
        check("lu_ifid_en", if_id_enable, 0);
        step();
        check("lu_bubble", id_ex_valid, 0);
        check("lu_bubble_rw", reg_write, 0);
        check("lu_count", stall_cycles, 1);
        ex_mem_read = 1'b0;
        #1;
        check("lu_release", pc_enable, 1);
        step();
        check("lu_issue", id_ex_valid, 1);
        check("lu_issue_a", reg_a, 32'h1234);
        check("lu_issue_b", reg_b, 3);
        check("lu_count_hold", stall_cycles, 1);

        // load with rd=x0 in EX never stalls
        ex_mem_read = 1'b1; ex_rd = 0; instruction = enc_r(6, 0, 1);
        #1;
        check("lu_x0", pc_enable, 1);
        ex_mem_read = 1'b0;

        // BEQ x1,x2,+16 at 0x100, x1=x2=3
        pc = 32'h100; instruction = enc_b(1, 2, 3'b000, 13'd16);
        #1;
        check("beq_taken", branch_taken, 1);
        check("beq_ifflush", if_flush, 1);
        check("beq_target", branch_target, 32'h110);
        step();
        check("beq_valid", id_ex_valid, 1);
        check("beq_imm", imm, 16);
        check("beq_aluop", alu_op, 2'b01);
        check("beq_rw", reg_write, 0);

        wb_write(2, 4);
        if_id_valid = 1'b1; pc = 32'h100; instruction = enc_b(1, 2, 3'b000, 13'd16);
        #1;
        check("beq_nt", branch_taken, 0);
        check("beq_nt_flush", if_flush, 0);
        instruction = enc_b(1, 2, 3'b001, 13'd16);
        #1;
        check("bne_taken", branch_taken, 1);

        // branch operand hazards
        instruction = enc_b(1, 2, 3'b001, 13'd16); ex_reg_write = 1'b1; ex_rd = 1;
        #1;
        check("bh_ex_pc_en", pc_enable, 0);
        check("bh_ex_taken", branch_taken, 0);
        step();
        check("bh_ex_bubble", id_ex_valid, 0);
        check("bh_ex_count", stall_cycles, 2);
        ex_reg_write = 1'b0; mem_mem_read = 1'b1; mem_rd = 2;
        #1;
        check("bh_mem_pc_en", pc_enable, 0);
        step();
        check("bh_mem_count", stall_cycles, 3);
        mem_mem_read = 1'b0;

        // JAL x1,-8 at 0x200
        pc = 32'h200; instruction = enc_j(1, 21'h1FFFF8);
        #1;
        check("jal_taken", branch_taken, 1);
        check("jal_target", branch_target, 32'h1F8);
        step();
        check("jal_isjal", is_jal, 1);
        check("jal_rw", reg_write, 1);
        check("jal_imm", imm, 32'hFFFFFFF8);

        // I-ALU, STORE, LOAD
        instruction = enc_i(3, 1, 12'hFFF, 7'b0010011);
        step();
        check("addi_imm", imm, 32'hFFFFFFFF);
        check("addi_src", alu_src, 1);
        check("addi_aluop", alu_op, 2'b11);
        instruction = enc_s(1, 2, 12'hFFC);
        step();
        check("sw_imm", imm, 32'hFFFFFFFC);
        check("sw_mw", mem_write, 1);
        check("sw_rw", reg_write, 0);
        instruction = enc_i(4, 1, 12'd8, 7'b0000011);
        step();
        check("lw_m2r", mem_to_reg, 1);
        check("lw_mr", mem_read, 1);
        check("lw_imm", imm, 8);

        // load-use stall, then flush on top of it
        ex_mem_read = 1'b1; ex_rd = 5; instruction = enc_r(6, 5, 1);
        step();
        check("fl_pre_count", stall_cycles, 4);
        flush = 1'b1;
        #1;
        check("fl_pc_en", pc_enable, 1);
        check("fl_ifid_en", if_id_enable, 1);
        step();
        check("fl_bubble", id_ex_valid, 0);
        check("fl_count", stall_cycles, 4);
        pc = 32'h100; instruction = enc_b(1, 2, 3'b001, 13'd16); ex_mem_read = 1'b0;
        #1;
        check("fl_no_branch", branch_taken, 0);
        flush = 1'b0;

        // unknown opcode
        instruction = 32'h0000007F;
        step();
        check("ill_flag", illegal, 1);
        check("ill_valid", id_ex_valid, 0);
        if_id_valid = 1'b0;
        step();
        check("ill_clear", illegal, 0);

        // reset while stalled
        if_id_valid = 1'b1; instruction = enc_r(6, 5, 1);
        step();
        check("pre_rst_valid", id_ex_valid, 1);
        ex_mem_read = 1'b1; ex_rd = 5; reset = 1'b1;
        step();
        check("mid_rst_valid", id_ex_valid, 0);
        check("mid_rst_a", reg_a, 0);
        check("mid_rst_pc", pc_out, 0);
        check("mid_rst_count", stall_cycles, 0);
        reset = 1'b0; ex_mem_read = 1'b0;
        step();
        check("rf_cleared", reg_a, 0);
        check("rf_valid", id_ex_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
- Parametrised instruction-decode stage for the pipelined RV32 core; successor of the fixed-width decode stage.
- Integrates an NREGS x XLEN register file with write-through bypass, the control decoder, and the immediate generator.
- Resolves BEQ/BNE/JAL in ID and detects load-use and branch-operand hazards.
- Drives a registered ID/EX interface with valid bit, bubble insertion, external flush and a saturating stall-cycle counter.

Parameters:
- XLEN, 32, datapath/register width (≥32).
- NREGS, 32, architectural registers (power of 2, ≤32); AW = clog2(NREGS).
- WRITE_BYPASS, 1, 1 = same-cycle WB data bypassed to ID reads.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- if_id_valid  in  1  IF/ID holds a real instruction
- instruction  in  32  IF/ID instruction
- pc  in  XLEN  IF/ID PC
- wb_enable  in  1  register-file write strobe
- wb_addr  in  AW  write address
- wb_data  in  XLEN  write data
- ex_rd  in  AW  destination of instruction in EX
- ex_reg_write  in  1  EX instruction writes a register
- ex_mem_read  in  1  EX instruction is a load
- mem_rd  in  AW  destination in MEM
- mem_mem_read  in  1  MEM instruction is a load
- flush  in  1  squash ID (later-stage redirect)
- pc_enable, if_id_enable  out  1  0 = hold PC / IF/ID
- if_flush  out  1  squash IF/ID contents (taken branch/JAL)
- branch_taken  out  1  redirect PC to branch_target
- branch_target  out  XLEN  pc + imm
- id_ex_valid, mem_to_reg, reg_write, mem_read, mem_write, alu_src, is_jal  out  1  registered control
- alu_op  out  2  registered ALU class
- rs1, rs2, rd  out  AW  registered register indices
- imm, reg_a, reg_b, pc_out  out  XLEN  registered operands
- funct7  out  7  registered funct7; funct3  out  3  registered funct3
- illegal  out  1  registered: unknown opcode seen
- stall_cycles  out  32  saturating count of stall cycles

Behaviour:
- Reset (synchronous):
  - All registered outputs and stall_cycles → 0.
  - All register-file entries → 0.
  - Takes priority over every other event.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Write occurs on the clock edge when wb_enable.
  - Reads are combinational. If WRITE_BYPASS=1 and wb_enable, wb_addr==rs, rs≠0: the read returns wb_data.
- Decode (opcode → mem_to_reg, reg_write, mem_read, mem_write, alu_src, alu_op, is_jal):
  - LOAD 0000011 → 1,1,1,0,1,00,0
  - STORE 0100011 → 0,0,0,1,1,00,0
  - R 0110011 → 0,1,0,0,0,10,0
  - I-ALU 0010011 → 0,1,0,0,1,11,0
  - BRANCH 1100011 → all 0, alu_op 01
  - JAL 1101111 → reg_write=1, is_jal=1, rest 0
  - Any other opcode with if_id_valid → bubble, illegal=1 for one cycle.
- Immediates:
  - I/S/B/J sign-extended to XLEN per RV32 encoding.
  - B and J immediates have bit0 = 0.
  - R-type imm = 0.
- Source usage: rs1 is used by all types except JAL; rs2 is used by R, STORE and BRANCH.
- Hazard (stall) conditions, each ANDed with if_id_valid and !flush; reg ≠ 0 required:
  - Load-use: ex_mem_read && ex_rd == a used source.
  - Branch operand (BRANCH only):
    - (ex_reg_write && ex_rd == rs1/rs2), or
    - (mem_mem_read && mem_rd == rs1/rs2).
- Stall effects:
  - pc_enable = 0, if_id_enable = 0.
  - ID/EX loads a bubble: id_ex_valid and all control bits = 0; data fields don't-care.
  - branch_taken = 0.
  - stall_cycles += 1, saturating at 0xFFFFFFFF.
- Branch:
  - Not stalled, valid, BRANCH: taken if funct3=000 and reg_a==reg_b, or funct3=001 and reg_a≠reg_b.
  - JAL is always taken.
  - When taken: branch_taken = 1 and if_flush = 1 (combinational, same cycle); branch_target = pc + imm (mod 2^XLEN).
  - The branch itself proceeds to ID/EX with valid=1.
- flush:
  - ID/EX gets a bubble.
  - branch_taken, if_flush and stall are forced to 0; pc_enable = if_id_enable = 1.
- if_id_valid = 0: bubble into ID/EX, no stall, no branch.
- Priority: reset > flush > stall > normal.
- Latency: one cycle from IF/ID to ID/EX outputs. Branch resolution is zero-cycle (combinational in ID).

Test Plan:
1. Reset, then write x5 = 0x1234 via WB; issue ADD x6,x5,x0 → reg_a=0x1234, reg_b=0, reg_write=1, alu_op=10, id_ex_valid=1 one cycle later. Write to x0 followed by a read → reads 0.
2. WB writes x7 = 0xAA in the same cycle ID reads x7 (WRITE_BYPASS=1) → reg_a=0xAA.
3. ex_mem_read=1, ex_rd=5; ID holds ADD x6,x5,x1 → pc_enable=0, if_id_enable=0, ID/EX bubble, stall_cycles=1. Next cycle with ex_mem_read=0 → ADD issues.
4. BEQ x1,x2,+16 at pc=0x100 with x1=x2=3 → branch_taken=1, if_flush=1, branch_target=0x110. Same with x2=4 → not taken. BNE with x2=4 → taken.
5. BEQ with ex_reg_write=1, ex_rd=1 → stall and branch_taken=0. JAL x1,-8 at pc=0x200 → target 0x1F8, is_jal=1, reg_write=1.
6. Mid-stall assertion of flush → bubble, pc_enable=1, no stall count. Opcode 0x7F → illegal=1, id_ex_valid=0. Reset asserted mid-stall → all outputs 0 next edge.
